processing_array_nxn: RTL and testbench

Parametrised output-stationary systolic MAC array computing C += A·B for NxN tiles with a programmable inner dimension K. Successor of the fixed 3x3 array: it adds generic N and widths, internal input skewing, bubble-tolerant streaming, a beat counter with automatic drain and done, and selectable wrap or saturate accumulation. Sits between the operand-streaming buffers and the result writeback in the CNN accelerator datapath.

---
 rtl/processing_array_pkg.sv | 26 ++
 rtl/pe_mac.sv | 76 +++++++
 rtl/processing_array_nxn.sv | 234 +++++++++++++++++++++++
 tb/tb_processing_array_nxn.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/processing_array_pkg.sv
// Shared types and constants for the NxN output-stationary systolic MAC array.
package processing_array_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_N      = 3;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ACC_W  = 32;
  localparam int unsigned DEF_K_W    = 8;

  // Largest positive two's-complement value of an acc_w-bit accumulator (acc_w <= 64).
  function automatic logic [63:0] sat_max(input int unsigned acc_w);
    return (64'd1 << (acc_w - 32'd1)) - 64'd1;
  endfunction

  // Most negative value of an acc_w-bit accumulator, in its low acc_w bits.
  function automatic logic [63:0] sat_min(input int unsigned acc_w);
    return 64'd1 << (acc_w - 32'd1);
  endfunction

endpackage

// File: rtl/pe_mac.sv
// One systolic cell: forwards operands east/south with their valid bit and
// accumulates a*b on valid beats, wrapping or saturating on signed overflow.
module pe_mac
  import processing_array_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_saturate,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_valid,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic              o_valid,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_ovf_c
);

  localparam int unsigned      PROD_W  = 2 * DATA_W;
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

  logic [DATA_W-1:0]        a_q, a_d, b_q, b_d;
  logic                     valid_q, valid_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic signed [PROD_W-1:0] a_ext_c, b_ext_c, prod_c;
  logic signed [ACC_W-1:0]  prod_ext_c;
  logic [ACC_W-1:0]         sum_c;
  logic                     ovf_raw_c;

  always_comb begin
    a_ext_c    = PROD_W'($signed(i_a));
    b_ext_c    = PROD_W'($signed(i_b));
    prod_c     = a_ext_c * b_ext_c;
    prod_ext_c = ACC_W'(prod_c);
    sum_c      = acc_q + prod_ext_c;
    // Overflow only possible when both addends share a sign.
    ovf_raw_c  = (acc_q[ACC_W-1] == prod_ext_c[ACC_W-1]) && (sum_c[ACC_W-1] != acc_q[ACC_W-1]);

    acc_d   = acc_q;
    a_d     = i_clear ? '0 : i_a;
    b_d     = i_clear ? '0 : i_b;
    valid_d = i_valid && !i_clear;
    o_ovf_c = i_valid && !i_clear && ovf_raw_c;
    if (i_clear) begin
      acc_d = '0;
    end else if (i_valid) begin
      if (ovf_raw_c && i_saturate) acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
      else                         acc_d = sum_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      acc_q   <= acc_d;
    end
  end

  assign o_a     = a_q;
  assign o_b     = b_q;
  assign o_valid = valid_q;
  assign o_acc   = acc_q;

endmodule

// File: rtl/processing_array_nxn.sv
// Output-stationary NxN systolic MAC array (C += A*B) with input skew, job FSM and drain counter.
// Optional PE_OVF_MAP_EN adds o_overflow_map with one sticky overflow bit per PE.
module processing_array_nxn
  import processing_array_pkg::*;
#(
  parameter int unsigned N      = DEF_N,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned K_W    = DEF_K_W
) (
  input  logic                   clk,
  input  logic                   i_reset,
  input  logic [N*DATA_W-1:0]    i_a_vector,
  input  logic [N*DATA_W-1:0]    i_b_vector,
  input  logic                   i_data_valid,
  input  logic [K_W-1:0]         i_k_len,
  input  logic                   i_saturate,
  input  logic                   i_read_enable,
  input  logic                   i_clear_acc,
  output logic                   o_ready,
  output logic [N*N*ACC_W-1:0]   o_result_matrix,
  output logic                   o_computation_done,
  output logic                   o_overflow_detected
`ifdef PE_OVF_MAP_EN
  ,
  output logic [N*N-1:0]         o_overflow_map
`endif
);

  localparam int unsigned CNT_W     = K_W + 1;
  localparam int unsigned DRAIN_LEN = 2 * N - 1;
  localparam int unsigned DRN_W     = $clog2(2 * N);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, k_len_q, k_len_d, k_eff_c;
  logic [DRN_W-1:0]  drain_q, drain_d;
  logic              sat_q, sat_d, sat_eff_c;
  logic              ready_q, ready_d, done_q, done_d;
  logic              accept_c;
  logic [N*N-1:0]    ovf_evt_c;

  assign accept_c  = i_data_valid && ready_q && !i_clear_acc;
  assign k_eff_c   = (i_k_len == '0) ? (CNT_W'(1) << K_W) : CNT_W'(i_k_len);
  // The first beat reaches PE(0,0) in the accepting cycle, before sat_q is loaded.
  assign sat_eff_c = (state_q == IDLE) ? i_saturate : sat_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_len_d = k_len_q;
    sat_d   = sat_q;
    drain_d = drain_q;
    if (i_clear_acc) begin
      state_d = IDLE;
      cnt_d   = '0;
      k_len_d = '0;
      sat_d   = 1'b0;
      drain_d = '0;
    end else begin
      case (state_q)
        IDLE: if (accept_c) begin
          k_len_d = k_eff_c;
          sat_d   = i_saturate;
          cnt_d   = CNT_W'(1);
          drain_d = '0;
          state_d = (k_eff_c == CNT_W'(1)) ? DRAIN : LOAD;
        end
        LOAD: if (accept_c) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == k_len_q) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
        DRAIN: begin
          drain_d = drain_q + DRN_W'(1);
          if (drain_q == DRN_W'(DRAIN_LEN - 1)) state_d = DONE;
        end
        DONE: if (i_read_enable) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    ready_d = (state_d == IDLE) || (state_d == LOAD);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_len_q <= '0;
      sat_q   <= 1'b0;
      drain_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_len_q <= k_len_d;
      sat_q   <= sat_d;
      drain_q <= drain_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign o_ready            = ready_q;
  assign o_computation_done = done_q;

  // Input skew: lane k is delayed k cycles; the valid bit rides with the A operand.
  logic [N-1:0][DATA_W-1:0] a_in, b_in, a_row, b_col;
  logic [N-1:0]             v_row;

  assign a_in     = i_a_vector;
  assign b_in     = i_b_vector;
  assign a_row[0] = a_in[0];
  assign b_col[0] = b_in[0];
  assign v_row[0] = accept_c;

  for (genvar k = 1; k < N; k++) begin : g_skew
    logic [DATA_W-1:0] a_q [k];
    logic [DATA_W-1:0] a_d [k];
    logic [DATA_W-1:0] b_q [k];
    logic [DATA_W-1:0] b_d [k];
    logic [k-1:0]      v_q, v_d;

    always_comb begin
      a_d[0] = i_clear_acc ? '0 : a_in[k];
      b_d[0] = i_clear_acc ? '0 : b_in[k];
      v_d    = '0;
      v_d[0] = accept_c;
      for (int d = 1; d < k; d++) begin
        a_d[d] = i_clear_acc ? '0 : a_q[d-1];
        b_d[d] = i_clear_acc ? '0 : b_q[d-1];
        v_d[d] = !i_clear_acc && v_q[d-1];
      end
    end

    always_ff @(posedge clk) begin
      if (!i_reset) begin
        for (int d = 0; d < k; d++) begin
          a_q[d] <= '0;
          b_q[d] <= '0;
        end
        v_q <= '0;
      end else begin
        for (int d = 0; d < k; d++) begin
          a_q[d] <= a_d[d];
          b_q[d] <= b_d[d];
        end
        v_q <= v_d;
      end
    end

    assign a_row[k] = a_q[k-1];
    assign b_col[k] = b_q[k-1];
    assign v_row[k] = v_q[k-1];
  end

  logic [N-1:0][N-1:0][DATA_W-1:0] pe_a, pe_b;
  logic [N-1:0][N-1:0]             pe_v;
  logic [N-1:0][N-1:0][ACC_W-1:0]  pe_acc;

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_W-1:0] a_w, b_n;
      logic              v_w;
      if (j == 0) begin : g_west_edge
        assign a_w = a_row[i];
        assign v_w = v_row[i];
      end else begin : g_west_pe
        assign a_w = pe_a[i][j-1];
        assign v_w = pe_v[i][j-1];
      end
      if (i == 0) begin : g_north_edge
        assign b_n = b_col[j];
      end else begin : g_north_pe
        assign b_n = pe_b[i-1][j];
      end

      pe_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_clear    (i_clear_acc),
        .i_saturate (sat_eff_c),
        .i_a        (a_w),
        .i_b        (b_n),
        .i_valid    (v_w),
        .o_a        (pe_a[i][j]),
        .o_b        (pe_b[i][j]),
        .o_valid    (pe_v[i][j]),
        .o_acc      (pe_acc[i][j]),
        .o_ovf_c    (ovf_evt_c[i*N+j])
      );
    end
  end

  assign o_result_matrix = pe_acc;

  // Operands leaving the east and south edges have no consumer.
  logic unused_edge_c;
  always_comb begin
    unused_edge_c = 1'b0;
    for (int k = 0; k < N; k++) begin
      unused_edge_c = unused_edge_c ^ (^pe_a[k][N-1]) ^ (^pe_b[N-1][k]) ^ pe_v[k][N-1];
    end
  end

`ifdef PE_OVF_MAP_EN
  logic [N*N-1:0] ovf_map_q, ovf_map_d;

  always_comb ovf_map_d = i_clear_acc ? '0 : (ovf_map_q | ovf_evt_c);

  always_ff @(posedge clk) begin
    if (!i_reset) ovf_map_q <= '0;
    else          ovf_map_q <= ovf_map_d;
  end

  assign o_overflow_map      = ovf_map_q;
  assign o_overflow_detected = |ovf_map_q;
`else
  logic ovf_q, ovf_d;

  always_comb ovf_d = i_clear_acc ? 1'b0 : (ovf_q || (|ovf_evt_c));

  always_ff @(posedge clk) begin
    if (!i_reset) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  assign o_overflow_detected = ovf_q;
`endif

endmodule

// File: tb/tb_processing_array_nxn.sv
// Self-checking bench for processing_array_nxn (N=3, 8-bit operands, 16-bit accumulators, K_W=2)
// against a job-level behavioural model of C += A*B with wrap/saturate semantics.
module tb_processing_array_nxn;

  localparam int N    = 3;
  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int KW   = 2;
  localparam int MAXK = 4;
  localparam longint ACC_MAX = 32767;
  localparam longint ACC_MIN = -32768;

  logic              clk = 1'b0;
  logic              i_reset = 1'b0;
  logic [N*DW-1:0]   i_a_vector = '0;
  logic [N*DW-1:0]   i_b_vector = '0;
  logic              i_data_valid = 1'b0;
  logic [KW-1:0]     i_k_len = '0;
  logic              i_saturate = 1'b0;
  logic              i_read_enable = 1'b0;
  logic              i_clear_acc = 1'b0;
  logic              o_ready;
  logic [N*N*AW-1:0] o_result_matrix;
  logic              o_computation_done;
  logic              o_overflow_detected;
`ifdef PE_OVF_MAP_EN
  logic [N*N-1:0]    o_overflow_map;
`endif

  processing_array_nxn #(.N(N), .DATA_W(DW), .ACC_W(AW), .K_W(KW)) dut (
    .clk                 (clk),
    .i_reset             (i_reset),
    .i_a_vector          (i_a_vector),
    .i_b_vector          (i_b_vector),
    .i_data_valid        (i_data_valid),
    .i_k_len             (i_k_len),
    .i_saturate          (i_saturate),
    .i_read_enable       (i_read_enable),
    .i_clear_acc         (i_clear_acc),
    .o_ready             (o_ready),
    .o_result_matrix     (o_result_matrix),
    .o_computation_done  (o_computation_done),
    .o_overflow_detected (o_overflow_detected)
`ifdef PE_OVF_MAP_EN
    ,
    .o_overflow_map      (o_overflow_map)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  typedef enum int {M_IDLE, M_LOAD, M_DRAIN, M_DONE} phase_e;
  phase_e m_phase = M_IDLE;
  longint m_c [N][N];
  bit     m_ovf = 1'b0;
  bit     m_sat = 1'b0;
  int     m_need = 0;
  int     m_got = 0;
  int     m_wait = 0;

  logic signed [DW-1:0] am [N][MAXK];
  logic signed [DW-1:0] bm [MAXK][N];
  int b_lit [N*N] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [63:0] getc(input int i, input int j);
    logic signed [AW-1:0] v;
    v = o_result_matrix[(i*N+j)*AW +: AW];
    return 64'(v);
  endfunction

  // Job-level model: each accepted beat is an outer product folded into C in beat order.
  task automatic model_clear();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m_c[i][j] = 0;
    m_ovf   = 1'b0;
    m_got   = 0;
    m_phase = M_IDLE;
  endtask

  task automatic model_beat();
    logic signed [DW-1:0] ai, bj;
    longint s;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ai = i_a_vector[i*DW +: DW];
        bj = i_b_vector[j*DW +: DW];
        s  = m_c[i][j] + longint'(ai) * longint'(bj);
        if (s > ACC_MAX || s < ACC_MIN) begin
          m_ovf = 1'b1;
          if (m_sat) s = (s > 0) ? ACC_MAX : ACC_MIN;
          else begin
            s = s & longint'(65535);
            if (s > ACC_MAX) s = s - 65536;
          end
        end
        m_c[i][j] = s;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!i_reset || i_clear_acc) model_clear();
    else begin
      case (m_phase)
        M_IDLE, M_LOAD: if (i_data_valid) begin
          if (m_phase == M_IDLE) begin
            m_need = (i_k_len == '0) ? (1 << KW) : int'(i_k_len);
            m_sat  = i_saturate;
            m_got  = 0;
          end
          model_beat();
          m_got++;
          if (m_got == m_need) begin
            m_phase = M_DRAIN;
            m_wait  = 2 * N - 1;
          end else m_phase = M_LOAD;
        end
        M_DRAIN: begin
          m_wait--;
          if (m_wait == 0) m_phase = M_DONE;
        end
        M_DONE: if (i_read_enable) m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison; results and overflow are only final while idle or done.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", o_ready, (m_phase == M_IDLE) || (m_phase == M_LOAD));
      check("done", o_computation_done, m_phase == M_DONE);
      if (m_phase == M_IDLE || m_phase == M_DONE) begin
        check("ovf", o_overflow_detected, m_ovf);
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) check("c_model", getc(i, j), m_c[i][j]);
      end
    end
  end

  task automatic check_all(input string name, input longint expv);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) check(name, getc(i, j), expv);
  endtask

  task automatic check_b(input string name, input int mult);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) check(name, getc(i, j), mult * b_lit[i*N+j]);
  endtask

  task automatic set_ident_b();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < MAXK; k++) am[i][k] = (i == k) ? 8'sd1 : 8'sd0;
    for (int k = 0; k < MAXK; k++)
      for (int j = 0; j < N; j++) bm[k][j] = (k < N) ? DW'(b_lit[k*N+j]) : 8'sd0;
  endtask

  task automatic fill_all(input int val);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < MAXK; k++) begin
        am[i][k] = DW'(val);
        bm[k][i] = DW'(val);
      end
  endtask

  task automatic drive_beat(input int kk);
    for (int i = 0; i < N; i++) i_a_vector[i*DW +: DW] = am[i][kk];
    for (int j = 0; j < N; j++) i_b_vector[j*DW +: DW] = bm[kk][j];
    i_data_valid = 1'b1;
  endtask

  task automatic pulse_clear();
    i_clear_acc = 1'b1;
    @(negedge clk);
    i_clear_acc = 1'b0;
  endtask

  task automatic do_read();
    i_read_enable = 1'b1;
    @(negedge clk);
    i_read_enable = 1'b0;
    check("done_after_read", o_computation_done, 0);
    check("ready_after_read", o_ready, 1);
  endtask

  // Streams nbeats beats, then counts edges from the last accepted beat until done.
  task automatic run_job(input int nbeats, input int klen, input bit sat, input bit bubble,
                         input bit junk, output int lat);
    i_k_len    = KW'(klen);
    i_saturate = sat;
    for (int kk = 0; kk < nbeats; kk++) begin
      drive_beat(kk);
      @(negedge clk);
      if (bubble && kk < nbeats - 1) begin
        i_data_valid = 1'b0;
        @(negedge clk);
      end
    end
    i_data_valid = junk;
    if (junk) begin
      i_a_vector = (N*DW)'($urandom);
      i_b_vector = (N*DW)'($urandom);
    end
    lat = 0;
    while (!o_computation_done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    i_data_valid = 1'b0;
    check("done_timeout", o_computation_done, 1);
  endtask

  initial begin
    int lat;
    int kr;
    int nb;

    repeat (2) @(negedge clk);
    i_reset = 1'b1;
    chk_en  = 1'b1;
    check("rst_ready", o_ready, 1);
    check("rst_done", o_computation_done, 0);
    check("rst_ovf", o_overflow_detected, 0);
    check_all("rst_c", 0);

    // Reset in the middle of a job discards everything in flight.
    set_ident_b();
    i_k_len = KW'(3);
    drive_beat(0);
    @(negedge clk);
    drive_beat(1);
    @(negedge clk);
    i_data_valid = 1'b0;
    i_reset      = 1'b0;
    @(negedge clk);
    i_reset = 1'b1;
    check("midrst_ready", o_ready, 1);
    check("midrst_done", o_computation_done, 0);
    check_all("midrst_c", 0);
    repeat (4) @(negedge clk);
    check_all("midrst_quiet_c", 0);

    run_job(3, 3, 1'b0, 1'b0, 1'b0, lat);
    check("lat_b2b", lat, 5);
    check_b("c_eq_b", 1);
    do_read();

    pulse_clear();
    run_job(3, 3, 1'b0, 1'b1, 1'b1, lat);
    check("lat_bubble", lat, 5);
    check_b("c_eq_b_bubble", 1);
    do_read();

    pulse_clear();
    fill_all(127);
    run_job(3, 3, 1'b0, 1'b0, 1'b0, lat);
    check_all("wrap_c", -17149);
    check("wrap_ovf", o_overflow_detected, 1);
    do_read();
    pulse_clear();
    check("clr_ovf", o_overflow_detected, 0);
    run_job(3, 3, 1'b1, 1'b0, 1'b0, lat);
    check_all("sat_c", 32767);
    check("sat_ovf", o_overflow_detected, 1);
    do_read();

    pulse_clear();
    set_ident_b();
    run_job(3, 3, 1'b0, 1'b0, 1'b0, lat);
    do_read();
    run_job(3, 3, 1'b0, 1'b0, 1'b0, lat);
    check_b("c_eq_2b", 2);
    do_read();
    pulse_clear();
    check_all("clr_c", 0);
    check("clr_ready", o_ready, 1);
    check("clr_done", o_computation_done, 0);

    fill_all(-128);
    run_job(1, 1, 1'b0, 1'b0, 1'b0, lat);
    check("lat_k1", lat, 5);
    check_all("k1_c", 16384);
    do_read();

    pulse_clear();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < MAXK; k++) begin
        am[i][k] = DW'($urandom);
        bm[k][i] = DW'($urandom);
      end
    run_job(4, 0, 1'b0, 1'b0, 1'b0, lat);
    check("lat_k0", lat, 5);
    do_read();

    for (int t = 0; t < 30; t++) begin
      kr = $urandom_range(0, 3);
      nb = (kr == 0) ? MAXK : kr;
      if ($urandom_range(0, 2) == 0) pulse_clear();
      for (int i = 0; i < N; i++)
        for (int k = 0; k < MAXK; k++) begin
          am[i][k] = DW'($urandom);
          bm[k][i] = DW'($urandom);
        end
      run_job(nb, kr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), lat);
      check("rand_lat", lat, 2 * N - 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_read();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
